// File: rtl/lpc_pkg.sv
// Shared types and defaults for the LPC analysis front end.
package lpc_pkg;

  localparam int LPC_N_SAMPLES = 160;
  localparam int LPC_ORDER     = 10;

  typedef logic signed [15:0] sample_t;
  typedef logic signed [31:0] acc_t;

  typedef enum logic [1:0] {
    LOAD,
    CLEAR,
    RUN,
    OUT
  } seq_state_t;

endpackage

// File: rtl/autocorr_frame_buf.sv
// One-frame sample store: a single write port and two combinational read
// ports, so x[n] and x[n-k] can be fetched in the same cycle.
module autocorr_frame_buf
  import lpc_pkg::*;
#(
  parameter int DEPTH = LPC_N_SAMPLES,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [AW-1:0] rd_addr_a,
  output logic [15:0]   rd_data_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [15:0]   rd_data_b
);

  sample_t mem [DEPTH];

  // NOTE: the array has no reset; every location is rewritten by LOAD before
  // it is read, and a reset would stop the array mapping onto RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/autocorr_lag_sequencer.sv
// Feeds sample pairs (x[n], x[n-k]) to the autocorrelation MAC for each lag
// and hands the captured R[k] values downstream over valid/ready.
module autocorr_lag_sequencer
  import lpc_pkg::*;
#(
  parameter int N_SAMPLES = LPC_N_SAMPLES,
  parameter int ORDER     = LPC_ORDER,
  parameter int AW        = $clog2(N_SAMPLES),
  parameter int KW        = $clog2(ORDER + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_data,
  output logic          mac_clear,
  output logic [15:0]   mac_x,
  output logic [15:0]   mac_x_lagged,
  output logic          mac_last,
  input  logic [31:0]   mac_y,
  output logic          r_valid,
  input  logic          r_ready,
  output logic [31:0]   r_data,
  output logic [KW-1:0] r_lag,
  output logic          r_last
);

  if (ORDER >= N_SAMPLES) begin : g_bad_params
    $error("autocorr_lag_sequencer: ORDER must be less than N_SAMPLES");
  end

  seq_state_t    state;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] n;
  logic [KW-1:0] k;
  logic [AW-1:0] k_ext;
  logic [AW-1:0] n_inc;
  logic [AW-1:0] rd_a;
  logic [AW-1:0] rd_b;
  logic [15:0]   buf_a;
  logic [15:0]   buf_b;
  logic          we;

  assign k_ext = AW'(k);
  assign n_inc = n + AW'(1);
  assign we    = in_valid && in_ready;

  // CLEAR prefetches the first pair of the lag; RUN fetches the next one.
  assign rd_a = (state == CLEAR) ? k_ext : n_inc;
  assign rd_b = rd_a - k_ext;

  autocorr_frame_buf #(
    .DEPTH (N_SAMPLES),
    .AW    (AW)
  ) u_buf (
    .clk       (clk),
    .we        (we),
    .wr_addr   (wr_cnt),
    .wr_data   (in_data),
    .rd_addr_a (rd_a),
    .rd_data_a (buf_a),
    .rd_addr_b (rd_b),
    .rd_data_b (buf_b)
  );

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch below reads the values from before this clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LOAD;
      wr_cnt       <= '0;
      n            <= '0;
      k            <= '0;
      in_ready     <= 1'b1;
      mac_clear    <= 1'b0;
      mac_last     <= 1'b0;
      mac_x        <= '0;
      mac_x_lagged <= '0;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      r_data       <= '0;
      r_lag        <= '0;
    end else begin
      mac_clear <= 1'b0;
      unique case (state)
        LOAD: begin
          if (we) begin
            if (wr_cnt == AW'(N_SAMPLES - 1)) begin
              wr_cnt    <= '0;
              k         <= '0;
              in_ready  <= 1'b0;
              mac_clear <= 1'b1;
              state     <= CLEAR;
            end else begin
              wr_cnt <= wr_cnt + AW'(1);
            end
          end
        end

        CLEAR: begin
          mac_x        <= buf_a;
          mac_x_lagged <= buf_b;
          n            <= k_ext;
          mac_last     <= (k_ext == AW'(N_SAMPLES - 1));
          state        <= RUN;
        end

        RUN: begin
          if (mac_last) begin
            // mac_y already includes the final pair presented this cycle.
            r_data       <= mac_y;
            r_lag        <= k;
            r_valid      <= 1'b1;
            r_last       <= (k == KW'(ORDER));
            mac_x        <= '0;
            mac_x_lagged <= '0;
            mac_last     <= 1'b0;
            state        <= OUT;
          end else begin
            mac_x        <= buf_a;
            mac_x_lagged <= buf_b;
            n            <= n_inc;
            mac_last     <= (n_inc == AW'(N_SAMPLES - 1));
          end
        end

        OUT: begin
          if (r_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (k == KW'(ORDER)) begin
              k        <= '0;
              in_ready <= 1'b1;
              state    <= LOAD;
            end else begin
              k         <= k + KW'(1);
              mac_clear <= 1'b1;
              state     <= CLEAR;
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_autocorr_lag_sequencer.sv
// Scoreboard bench: a behavioural MAC and an autocorrelation reference model
// predict every sample pair and every R[k]; a monitor compares as they appear.
module tb_autocorr_lag_sequencer;

  localparam int N   = 16;
  localparam int ORD = 2;
  localparam int KW  = $clog2(ORD + 1);

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          mac_clear;
  logic [15:0]   mac_x;
  logic [15:0]   mac_x_lagged;
  logic          mac_last;
  logic [31:0]   mac_y;
  logic          r_valid;
  logic          r_ready;
  logic [31:0]   r_data;
  logic [KW-1:0] r_lag;
  logic          r_last;

  autocorr_lag_sequencer #(
    .N_SAMPLES (N),
    .ORDER     (ORD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .mac_clear    (mac_clear),
    .mac_x        (mac_x),
    .mac_x_lagged (mac_x_lagged),
    .mac_last     (mac_last),
    .mac_y        (mac_y),
    .r_valid      (r_valid),
    .r_ready      (r_ready),
    .r_data       (r_data),
    .r_lag        (r_lag),
    .r_last       (r_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Behavioural MAC: exact sum of products, synchronously cleared.
  logic signed [31:0] xa, xb, prod, acc;
  assign xa    = {{16{mac_x[15]}}, mac_x};
  assign xb    = {{16{mac_x_lagged[15]}}, mac_x_lagged};
  assign prod  = xa * xb;
  assign mac_y = acc + prod;
  always @(posedge clk) begin
    if (mac_clear) acc <= '0;
    else           acc <= acc + prod;
  end

  typedef struct {
    logic [15:0] x;
    logic [15:0] xl;
    bit          last;
  } pair_t;

  typedef struct {
    logic [31:0] r;
    int          lag;
    bit          last;
  } res_t;

  pair_t       pair_q[$];
  res_t        res_q[$];
  logic [15:0] frame [N];

  int checks = 0;
  int failures = 0;
  int last_acc_cyc = 0;
  int hs_cyc = 0;
  int ready_mode = 0;
  int stalls = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: R[k] = sum over n=k..N-1 of x[n]*x[n-k], wrapped to 32 bits.
  task automatic build_expected();
    for (int k = 0; k <= ORD; k++) begin
      longint s = 0;
      for (int n = k; n < N; n++) begin
        s += longint'($signed(frame[n])) * longint'($signed(frame[n-k]));
        pair_q.push_back('{frame[n], frame[n-k], (n == N - 1)});
      end
      res_q.push_back('{32'(s), k, (k == ORD)});
    end
  endtask

  task automatic send_frame(input int gap_max);
    check("in_ready_at_frame_start", 64'(in_ready), 64'(1));
    build_expected();
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = frame[i];
      if (i == N - 1) last_acc_cyc = cyc;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit junk);
    int budget = 0;
    while ((res_q.size() != 0 || pair_q.size() != 0) && budget < 2000) begin
      if (junk && !in_ready && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        in_data  = 16'd7;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      budget++;
    end
    in_valid = 1'b0;
    if (budget >= 2000) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout: %0d results still pending after %0d cycles", res_q.size(), budget);
    end
  endtask

  // r_ready driver: 0 = always high, 1 = random, 2 = hold R[1] for 5 cycles.
  initial begin
    int stall_left;
    r_ready = 1'b0;
    stall_left = 5;
    forever begin
      tick();
      case (ready_mode)
        0: r_ready = 1'b1;
        1: r_ready = 1'($urandom_range(0, 1));
        default: begin
          if (r_valid && r_lag == KW'(1) && stall_left > 0) begin
            r_ready = 1'b0;
            stall_left--;
          end else begin
            r_ready = 1'b1;
          end
        end
      endcase
      if (ready_mode != 2) stall_left = 5;
    end
  end

  // Monitor: pops expected pairs while a lag runs and results on handshakes.
  bit          in_run = 0;
  bit          prev_valid = 0;
  bit          prev_stall = 0;
  logic [31:0] held_data;
  logic [KW-1:0] held_lag;
  int          clears = 0;

  always @(negedge clk) begin
    if (reset) begin
      pair_q.delete();
      res_q.delete();
      in_run = 0;
      prev_valid = 0;
      prev_stall = 0;
      clears = 0;
    end else begin
      if (in_run) begin
        if (pair_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pair_extra: mac_x=%0d mac_x_lagged=%0d with no pair expected", mac_x, mac_x_lagged);
          in_run = 0;
        end else begin
          pair_t p;
          p = pair_q.pop_front();
          check("mac_x", 64'(mac_x), 64'(p.x));
          check("mac_x_lagged", 64'(mac_x_lagged), 64'(p.xl));
          check("mac_last", 64'(mac_last), 64'(p.last));
          if (p.last) in_run = 0;
        end
      end else begin
        check("idle_mac_zero", 64'({mac_x, mac_x_lagged, mac_last}), 64'(0));
      end

      if (mac_clear) begin
        clears++;
        in_run = 1;
      end

      if (r_valid) begin
        check("busy_in_ready_clear", 64'({in_ready, mac_clear}), 64'(0));
        if (!prev_valid) begin
          if (r_lag == '0) check("latency_r0", 64'(cyc), 64'(last_acc_cyc + N + 2));
          else             check("latency_rk", 64'(cyc), 64'(hs_cyc + N - int'(r_lag) + 2));
        end
        if (prev_stall) begin
          check("stall_r_data", 64'(r_data), 64'(held_data));
          check("stall_r_lag", 64'(r_lag), 64'(held_lag));
        end
        if (r_ready) begin
          prev_stall = 0;
          hs_cyc = cyc;
          if (res_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL result_extra: r_data=%0d r_lag=%0d with no result expected", r_data, r_lag);
          end else begin
            res_t e;
            e = res_q.pop_front();
            check("r_data", 64'(r_data), 64'(e.r));
            check("r_lag", 64'(r_lag), 64'(e.lag));
            check("r_last", 64'(r_last), 64'(e.last));
            if (e.last) begin
              check("clears_per_frame", 64'(clears), 64'(ORD + 1));
              clears = 0;
            end
          end
        end else begin
          prev_stall = 1;
          held_data = r_data;
          held_lag = r_lag;
          stalls++;
        end
      end else begin
        if (prev_stall) check("stall_valid_held", 64'(r_valid), 64'(1));
        prev_stall = 0;
        check("r_last_idle", 64'(r_last), 64'(0));
      end
      prev_valid = r_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int b;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_mac_clear", 64'(mac_clear), 64'(0));
    check("rst_mac_last", 64'(mac_last), 64'(0));
    check("rst_mac_x", 64'({mac_x, mac_x_lagged}), 64'(0));
    check("rst_r_valid", 64'({r_valid, r_last}), 64'(0));
    check("rst_r_data", 64'(r_data), 64'(0));
    check("rst_r_lag", 64'(r_lag), 64'(0));

    // Constant frame of 3s: R = 144, 135, 126.
    ready_mode = 0;
    for (int i = 0; i < N; i++) frame[i] = 16'd3;
    send_frame(0);
    wait_done(0);

    // Ramp 1..N with input gaps: R[1] = 1360.
    for (int i = 0; i < N; i++) frame[i] = 16'(i + 1);
    send_frame(2);
    wait_done(0);

    // Downstream stalls R[1] for exactly five cycles.
    ready_mode = 2;
    s0 = stalls;
    for (int i = 0; i < N; i++) frame[i] = 16'($urandom);
    send_frame(1);
    wait_done(0);
    check("stall_cycles", 64'(stalls - s0), 64'(5));
    ready_mode = 0;

    // Reset in the middle of lag 1, then a fresh constant frame.
    for (int i = 0; i < N; i++) frame[i] = 16'd3;
    send_frame(0);
    b = 0;
    while (res_q.size() != ORD && b < 500) begin
      tick();
      b++;
    end
    if (b >= 500) begin
      checks++;
      failures++;
      $display("FAIL wait_r0: R[0] handshake not seen within %0d cycles", b);
    end
    repeat (3) tick();
    check("pre_reset_in_run", 64'(mac_x), 64'(3));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'(1));
    check("abort_r_valid", 64'(r_valid), 64'(0));
    check("abort_mac_out", 64'({mac_x, mac_x_lagged, mac_clear, mac_last}), 64'(0));
    send_frame(0);
    wait_done(0);

    // Random frames with random back-pressure and stray in_valid pulses.
    ready_mode = 1;
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < N; i++) frame[i] = 16'($urandom);
      send_frame(3);
      wait_done(1);
    end
    ready_mode = 0;
    for (int i = 0; i < N; i++) frame[i] = 16'($urandom_range(0, 255));
    send_frame(0);
    wait_done(0);

    repeat (2) tick();
    check("queues_drained", 64'(pair_q.size() + res_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
